// File: rtl/dpa_pkg.sv
// Shared definitions for the DPA pixel scaler: photo size codes, frame size,
// scaler FSM states and the colour channel width.
package dpa_pkg;

    localparam int CH_W   = 8;
    localparam int FB_PIX = 65536;

    localparam logic [1:0] SZ_128 = 2'b01;
    localparam logic [1:0] SZ_256 = 2'b10;
    localparam logic [1:0] SZ_512 = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT   = 2'd1,
        REPLICATE = 2'd2
    } scaler_state_t;

endpackage

// File: rtl/dpa_ch_avg4.sv
// One colour channel of the 2x2 averager. Keeps a 10-bit running sum of the
// first three pixels of a group and presents the average of all four on the
// cycle the fourth pixel arrives.
// DPA_SCALER_ROUND_EN defined: round-half-up ((sum+2)>>2); otherwise truncate.
module dpa_ch_avg4
    import dpa_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            add,
    input  logic            last,
    input  logic [CH_W-1:0] din,
    output logic [CH_W-1:0] avg
);

    logic [CH_W+1:0] sum;
    logic [CH_W+1:0] total;
    logic [CH_W+1:0] rounded;

    // Four 8-bit values sum to at most 1020, and 1020+2 still fits in 10 bits.
    assign total = sum + {2'b00, din};

`ifdef DPA_SCALER_ROUND_EN
    assign rounded = total + (CH_W+2)'(2);
`else
    assign rounded = total;
`endif

    assign avg = CH_W'(rounded >> 2);

    // Running sum; restarts after each complete group or while the scaler is idle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= last ? '0 : total;
        end
    end

endmodule

// File: rtl/dpa_pix_scaler.sv
// Pixel-rate scaler from the image-memory read stream to the 256x256 frame
// buffer: 512 photos are 2x2 averaged, 256 photos pass through, 128 photos are
// replicated four times. Rounding of the average is selected by the
// DPA_SCALER_ROUND_EN macro (see dpa_ch_avg4).
module dpa_pix_scaler
    import dpa_pkg::*;
#(
    parameter int FB_PIX = dpa_pkg::FB_PIX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_pix,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_pix,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [15:0] LAST_CNT = 16'(FB_PIX - 1);

    scaler_state_t state;
    scaler_state_t next_state;

    logic [1:0]  mode;
    logic [1:0]  in_cnt;
    logic [1:0]  rep_cnt;
    logic [15:0] out_cnt;
    logic        in_fire;
    logic        out_fire;
    logic        last_out;
    logic [23:0] avg_pix;

    assign out_fire = out_valid && out_ready;
    assign last_out = (out_cnt == LAST_CNT);

    // Three identical channel averagers, R in [23:16], G in [15:8], B in [7:0].
    for (genvar ch = 0; ch < 3; ch++) begin : g_avg
        dpa_ch_avg4 u_avg (
            .clk   (clk),
            .reset (reset),
            .clear (state == IDLE),
            .add   (in_fire && (mode == SZ_512)),
            .last  (in_cnt == 2'd3),
            .din   (in_pix[ch*CH_W +: CH_W]),
            .avg   (avg_pix[ch*CH_W +: CH_W])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and input handshake; no input is taken once the final frame pixel is pending.
    always_comb begin
        next_state = state;
        in_ready   = (state == COLLECT) && (!out_valid || out_ready) && !(out_valid && last_out);
        in_fire    = in_valid && in_ready;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (out_fire && last_out) begin
                    next_state = IDLE;
                end else if (in_fire && (mode == SZ_128)) begin
                    next_state = REPLICATE;
                end
            end
            REPLICATE: begin
                if (out_fire && last_out) begin
                    next_state = IDLE;
                end else if (out_fire && (rep_cnt == 2'd0)) begin
                    next_state = COLLECT;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: consume first, then a new result overrides so back-to-back outputs have no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode       <= SZ_256;
            out_valid  <= 1'b0;
            out_pix    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            in_cnt     <= '0;
            rep_cnt    <= '0;
            out_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;

            if ((state == IDLE) && start) begin
                mode    <= (size == 2'b00) ? SZ_256 : size;
                busy    <= 1'b1;
                in_cnt  <= '0;
                rep_cnt <= '0;
            end

            if (out_fire) begin
                if (last_out) begin
                    out_cnt    <= '0;
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    out_valid  <= 1'b0;
                    rep_cnt    <= '0;
                    in_cnt     <= '0;
                end else begin
                    out_cnt <= out_cnt + 16'd1;
                    if ((state == REPLICATE) && (rep_cnt != 2'd0)) begin
                        rep_cnt <= rep_cnt - 2'd1;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
            end

            if (in_fire) begin
                case (mode)
                    SZ_512: begin
                        in_cnt <= in_cnt + 2'd1;
                        if (in_cnt == 2'd3) begin
                            out_pix   <= avg_pix;
                            out_valid <= 1'b1;
                        end
                    end
                    SZ_128: begin
                        out_pix   <= in_pix;
                        out_valid <= 1'b1;
                        rep_cnt   <= 2'd3;
                    end
                    default: begin
                        out_pix   <= in_pix;
                        out_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dpa_pix_scaler.sv
// Directed bench for dpa_pix_scaler, built with a 16-pixel frame so whole
// frames fit in a short run. Expected 512-mode averages follow DPA_SCALER_ROUND_EN.
module tb_dpa_pix_scaler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_pix = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_pix;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad = 0;

`ifdef DPA_SCALER_ROUND_EN
    localparam logic [7:0] EXP_R_A = 8'h02;
    localparam logic [7:0] EXP_R_B = 8'h01;
`else
    localparam logic [7:0] EXP_R_A = 8'h01;
    localparam logic [7:0] EXP_R_B = 8'h00;
`endif

    dpa_pix_scaler #(.FB_PIX(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .size       (size),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pix     (in_pix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pix    (out_pix),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Absolute time limit so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [23:0] pat(int k);
        return {8'(k * 17), 8'(255 - k), 8'h3C};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pix = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] s);
        @(negedge clk);
        start = 1'b1; size = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; in_pix = 24'h123456; out_ready = 1'b1; start = 1'b1; size = 2'b11;
        @(negedge clk);
        @(negedge clk); #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_in_ready: got %b expected 0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
        total++; if (out_pix !== 24'h0) begin bad++; $display("[TB] FAIL rst_out_pix: got %h expected 000000", out_pix); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_frame_done: got %b expected 0", frame_done); end
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_mode256();
        do_reset();
        do_start(2'b10);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL m256_busy: got %b expected 1", busy); end
        in_valid = 1'b1; in_pix = 24'h102030; out_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL m256_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_pix = 24'hFFFFFF; #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL m256_valid0: got %b expected 1", out_valid); end
        total++; if (out_pix !== 24'h102030) begin bad++; $display("[TB] FAIL m256_pix0: got %h expected 102030", out_pix); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL m256_in_ready1: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL m256_valid1: got %b expected 1", out_valid); end
        total++; if (out_pix !== 24'hFFFFFF) begin bad++; $display("[TB] FAIL m256_pix1: got %h expected ffffff", out_pix); end
        @(negedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL m256_drain: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_mode512();
        do_reset();
        do_start(2'b11);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            in_valid = 1'b1; in_pix = {8'(k), 8'hFF, 8'hFF}; #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL m512_in_ready[%0d]: got %b expected 1", k, in_ready); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL m512_early_out[%0d]: got %b expected 0", k, out_valid); end
        end
        @(negedge clk);
        in_valid = 1'b0; #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL m512_valid: got %b expected 1", out_valid); end
        total++; if (out_pix !== {EXP_R_A, 8'hFF, 8'hFF}) begin bad++; $display("[TB] FAIL m512_avg: got %h expected %h", out_pix, {EXP_R_A, 8'hFF, 8'hFF}); end
        @(negedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL m512_single: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_mode128();
        int rdy_seq [5] = '{1, 0, 1, 1, 1};
        int hs = 0;
        do_reset();
        do_start(2'b01);
        in_valid = 1'b1; in_pix = 24'hABCDEF; out_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL m128_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            out_ready = rdy_seq[i][0]; #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL m128_valid[%0d]: got %b expected 1", i, out_valid); end
            total++; if (out_pix !== 24'hABCDEF) begin bad++; $display("[TB] FAIL m128_pix[%0d]: got %h expected abcdef", i, out_pix); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL m128_rep_in_ready[%0d]: got %b expected 0", i, in_ready); end
            if (out_valid && out_ready) hs++;
            @(negedge clk);
        end
        out_ready = 1'b0; #1;
        total++; if (hs !== 4) begin bad++; $display("[TB] FAIL m128_count: got %0d expected 4", hs); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL m128_end_valid: got %b expected 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL m128_back_collect: got %b expected 1", in_ready); end
    endtask

    task automatic test_full_frame();
        logic [23:0] pix [5] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC, 24'hDEAD01};
        int hs = 0;
        int acc = 0;
        logic exp_done = 1'b0;
        logic done_seen = 1'b0;
        do_reset();
        do_start(2'b01);
        for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            if (cyc != 0) @(negedge clk);
            in_valid = 1'b1; in_pix = pix[(acc < 4) ? acc : 4]; out_ready = 1'b1; #1;
            total++; if (frame_done !== exp_done) begin bad++; $display("[TB] FAIL ff_done@hs%0d: got %b expected %b", hs, frame_done, exp_done); end
            if (exp_done) begin
                done_seen = 1'b1;
                total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ff_busy_drop: got %b expected 0", busy); end
            end else begin
                total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL ff_busy@hs%0d: got %b expected 1", hs, busy); end
                if (in_valid && in_ready) acc++;
                if (out_valid && out_ready) begin
                    total++; if (out_pix !== pix[hs / 4]) begin bad++; $display("[TB] FAIL ff_pix[%0d]: got %h expected %h", hs, out_pix, pix[hs / 4]); end
                    hs++;
                    exp_done = (hs == 16);
                end
            end
        end
        total++; if (done_seen !== 1'b1) begin bad++; $display("[TB] FAIL ff_timeout: got hs=%0d expected 16", hs); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL ff_post_in_ready[%0d]: got %b expected 0", i, in_ready); end
            total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL ff_done_pulse[%0d]: got %b expected 0", i, frame_done); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ff_post_valid[%0d]: got %b expected 0", i, out_valid); end
        end
        total++; if (acc !== 4) begin bad++; $display("[TB] FAIL ff_inputs: got %0d expected 4", acc); end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        int hs = 0;
        int acc = 0;
        logic exp_done = 1'b0;
        logic done_seen = 1'b0;
        do_reset();
        do_start(2'b10);
        for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            if (cyc != 0) @(negedge clk);
            start = (cyc == 3); size = (cyc == 3) ? 2'b11 : 2'b10;
            in_valid = 1'b1; in_pix = pat(acc); out_ready = 1'b1; #1;
            total++; if (frame_done !== exp_done) begin bad++; $display("[TB] FAIL si_done@hs%0d: got %b expected %b", hs, frame_done, exp_done); end
            if (exp_done) begin
                done_seen = 1'b1;
            end else begin
                total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL si_busy@hs%0d: got %b expected 1", hs, busy); end
                if (in_valid && in_ready) acc++;
                if (out_valid && out_ready) begin
                    total++; if (out_pix !== pat(hs)) begin bad++; $display("[TB] FAIL si_pix[%0d]: got %h expected %h", hs, out_pix, pat(hs)); end
                    hs++;
                    exp_done = (hs == 16);
                end
            end
        end
        start = 1'b0;
        total++; if (done_seen !== 1'b1) begin bad++; $display("[TB] FAIL si_timeout: got hs=%0d expected 16", hs); end
        total++; if (acc !== 16) begin bad++; $display("[TB] FAIL si_inputs: got %0d expected 16", acc); end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [23:0] grp [4] = '{24'h001040, 24'h001040, 24'h011040, 24'h011140};
        do_reset();
        do_start(2'b11);
        out_ready = 1'b1;
        in_valid = 1'b1; in_pix = 24'h80FFFF;
        @(negedge clk);
        in_pix = 24'h80FFFF;
        @(negedge clk);
        in_valid = 1'b1; reset = 1'b1;
        @(negedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rm_valid: got %b expected 0", out_valid); end
        total++; if (out_pix !== 24'h0) begin bad++; $display("[TB] FAIL rm_pix: got %h expected 000000", out_pix); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rm_busy: got %b expected 0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rm_in_ready: got %b expected 0", in_ready); end
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk); #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rm_idle: got %b expected 0", in_ready); end
        do_start(2'b11);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            in_valid = 1'b1; in_pix = grp[k];
        end
        @(negedge clk);
        in_valid = 1'b0; #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rm_new_valid: got %b expected 1", out_valid); end
        total++; if (out_pix !== {EXP_R_B, 8'h10, 8'h40}) begin bad++; $display("[TB] FAIL rm_new_avg: got %h expected %h", out_pix, {EXP_R_B, 8'h10, 8'h40}); end
        out_ready = 1'b0;
    endtask

    initial begin
        $display("[TB] starting dpa_pix_scaler bench");
        test_reset();
        test_mode256();
        test_mode512();
        test_mode128();
        test_full_frame();
        test_start_ignored();
        test_reset_midframe();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
